// File: rtl/comm_pkg.sv
// Shared types and constants for the QPSK frame synchronizer.
// The optional CRC-8 trailer is enabled by defining FRAME_SYNC_CRC_EN.
package comm_pkg;

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    PAY,
    CRC,
    END
  } fs_state_e;

  localparam logic [31:0] SYNC_WORD_DEFAULT = 32'h1ACF_FC1D;
  localparam logic [7:0]  CRC8_POLY         = 8'h07;

  // Number of set bits; used to measure the Hamming distance to the sync word.
  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/crc8_update.sv
// One-byte CRC-8 step (poly 0x07, MSB first, no reflection, no final XOR).
// Only present when FRAME_SYNC_CRC_EN is defined.
`ifdef FRAME_SYNC_CRC_EN
module crc8_update
  import comm_pkg::*;
(
  input  logic [7:0] crc_i,
  input  logic [7:0] data_i,
  output logic [7:0] crc_o
);

  logic [7:0] work;

  always_comb begin
    work = crc_i ^ data_i;
    for (int i = 0; i < 8; i++) begin
      if (work[7]) begin
        work = {work[6:0], 1'b0} ^ CRC8_POLY;
      end else begin
        work = {work[6:0], 1'b0};
      end
    end
    crc_o = work;
  end

endmodule
`endif

// File: rtl/qpsk_frame_sync.sv
// Sync-word hunter and byte assembler behind the QPSK demapper.
// Define FRAME_SYNC_CRC_EN to add the CRC-8 trailer check; default build has none.
module qpsk_frame_sync
  import comm_pkg::*;
#(
  parameter logic [31:0] SYNC_WORD = SYNC_WORD_DEFAULT,
  parameter int          SYNC_TOL  = 0,
  parameter int          MAX_LEN   = 64
) (
  input  logic       ck,
  input  logic       rst,
  input  logic       ce,
  input  logic       valid_i,
  input  logic [1:0] sym_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_start_o,
  output logic       frame_end_o,
  output logic       crc_ok_o,
  output logic       len_err_o,
  output logic       locked_o
);

  localparam logic [5:0] TOL6    = 6'(SYNC_TOL);
  localparam logic [7:0] MAXLEN8 = 8'(MAX_LEN);

  fs_state_e   state_q;
  logic [31:0] sr_q;
  logic [4:0]  huntCnt_q;
  logic [1:0]  dibCnt_q;
  logic [5:0]  acc_q;
  logic [7:0]  len_q;
  logic [7:0]  byte_q;
  logic        byteValid_q;
  logic        frameStart_q;
  logic        frameEnd_q;
  logic        crcOk_q;
  logic        lenErr_q;

  logic [31:0] sr_d;
  logic [4:0]  huntCnt_d;
  logic        syncHit;
  logic [7:0]  byteFull;

  assign sr_d      = {sr_q[29:0], sym_i};
  assign huntCnt_d = (huntCnt_q == 5'd16) ? huntCnt_q : huntCnt_q + 5'd1;
  assign syncHit   = (huntCnt_d == 5'd16) && (popcount32(sr_d ^ SYNC_WORD) <= TOL6);
  assign byteFull  = {acc_q, sym_i};

`ifdef FRAME_SYNC_CRC_EN
  logic [7:0] crc_q;
  logic [7:0] crcSeed;
  logic [7:0] crcNext;
  logic       crcMatch_q;

  // The length byte starts a fresh CRC, so it is folded in from a zero seed.
  assign crcSeed = (state_q == LEN) ? 8'h00 : crc_q;

  crc8_update u_crc8 (
    .crc_i  (crcSeed),
    .data_i (byteFull),
    .crc_o  (crcNext)
  );
`endif

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q      <= HUNT;
      sr_q         <= '0;
      huntCnt_q    <= '0;
      dibCnt_q     <= '0;
      acc_q        <= '0;
      len_q        <= '0;
      byte_q       <= '0;
      byteValid_q  <= 1'b0;
      frameStart_q <= 1'b0;
      frameEnd_q   <= 1'b0;
      crcOk_q      <= 1'b0;
      lenErr_q     <= 1'b0;
`ifdef FRAME_SYNC_CRC_EN
      crc_q        <= '0;
      crcMatch_q   <= 1'b0;
`endif
    end else begin
      byteValid_q  <= 1'b0;
      frameStart_q <= 1'b0;
      frameEnd_q   <= 1'b0;
      lenErr_q     <= 1'b0;
      if (ce) begin
        unique case (state_q)
          HUNT: begin
            if (valid_i) begin
              sr_q      <= sr_d;
              huntCnt_q <= huntCnt_d;
              if (syncHit) begin
                state_q  <= LEN;
                dibCnt_q <= '0;
              end
            end
          end
          LEN, PAY, CRC: begin
            if (valid_i) begin
              dibCnt_q <= dibCnt_q + 2'd1;
              acc_q    <= {acc_q[3:0], sym_i};
              if (dibCnt_q == 2'd3) begin
                if (state_q == LEN) begin
                  if (byteFull == 8'd0 || byteFull > MAXLEN8) begin
                    lenErr_q  <= 1'b1;
                    state_q   <= HUNT;
                    sr_q      <= '0;
                    huntCnt_q <= '0;
                  end else begin
                    len_q        <= byteFull;
                    frameStart_q <= 1'b1;
                    state_q      <= PAY;
`ifdef FRAME_SYNC_CRC_EN
                    crc_q        <= crcNext;
`endif
                  end
                end else if (state_q == PAY) begin
                  byte_q      <= byteFull;
                  byteValid_q <= 1'b1;
                  len_q       <= len_q - 8'd1;
`ifdef FRAME_SYNC_CRC_EN
                  crc_q       <= crcNext;
                  if (len_q == 8'd1) state_q <= CRC;
`else
                  if (len_q == 8'd1) state_q <= END;
`endif
                end else begin
`ifdef FRAME_SYNC_CRC_EN
                  crcMatch_q <= (byteFull == crc_q);
`endif
                  state_q    <= END;
                end
              end
            end
          end
          END: begin
            // Any dibit arriving here is dropped; hunting restarts from scratch.
            frameEnd_q <= 1'b1;
`ifdef FRAME_SYNC_CRC_EN
            crcOk_q    <= crcMatch_q;
`else
            crcOk_q    <= 1'b1;
`endif
            sr_q       <= '0;
            huntCnt_q  <= '0;
            dibCnt_q   <= '0;
            state_q    <= HUNT;
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign byte_o        = byte_q;
  assign byte_valid_o  = byteValid_q;
  assign frame_start_o = frameStart_q;
  assign frame_end_o   = frameEnd_q;
  assign crc_ok_o      = crcOk_q;
  assign len_err_o     = lenErr_q;
  assign locked_o      = (state_q != HUNT);

endmodule

// File: doc/qpsk_frame_sync.md
# qpsk_frame_sync

Frame synchronizer and byte assembler directly downstream of the QPSK IQ demapper. Consumes the demapper's per-symbol hard-decision dibit stream (`raw` / `valid_raw`), hunts for a 32-bit sync word, then extracts a length byte, payload bytes and an optional CRC-8 trailer. Delivers one payload byte per strobe to the packet writer, with frame start/end/error flags.

## Interface
- `SYNC_WORD`, 32'h1ACF_FC1D: sync pattern, first received bit in bit 31.
- `SYNC_TOL`, 0: maximum mismatched bits (0..7) still accepted as sync.
- `MAX_LEN`, 64: largest legal payload length in bytes (1..255).
- `ck`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ce`  in  1  clock enable; when low, no state or output changes, except that pulse outputs drop.
- `valid_i`  in  1  dibit strobe; driven from demapper `valid_raw`.
- `sym_i`  in  2  hard-decision dibit; `sym_i[1]` is the earlier bit.
- `byte_o`  out  8  assembled payload byte.
- `byte_valid_o`  out  1  one-cycle strobe; `byte_o` is valid.
- `frame_start_o`  out  1  one-cycle pulse on acceptance of a legal length byte.
- `frame_end_o`  out  1  one-cycle pulse when the frame completes.
- `crc_ok_o`  out  1  qualifies `frame_end_o`; holds its value until the next `frame_end_o`.
- `len_err_o`  out  1  one-cycle pulse when the length byte is 0 or greater than `MAX_LEN`.
- `locked_o`  out  1  high outside HUNT.

## Operation
- An input is "taken" only when `ce && valid_i` is high. All other cycles are ignored.
- HUNT:
  - Each taken dibit shifts into a 32-bit register: `sr <= {sr[29:0], sym_i}`.
  - Sync is detected when popcount(`sr_next ^ SYNC_WORD`) ≤ `SYNC_TOL`, where `sr_next` includes the current dibit.
  - Detection requires at least 16 dibits taken since reset or the last exit from HUNT.
  - On detection, go to LEN and clear the dibit counter.
- Byte assembly:
  - 4 taken dibits form one byte, MSB first: first dibit → bits[7:6], fourth dibit → bits[1:0].
  - A 2-bit counter tracks position within the byte and wraps 3→0.
- LEN: the first byte after sync is the length byte.
  - If 0 or > `MAX_LEN`: pulse `len_err_o` and return to HUNT.
  - Otherwise: load the length counter, pulse `frame_start_o`, go to PAY.
- PAY:
  - Each completed byte pulses `byte_valid_o` and decrements the length counter.
  - After the last byte: go to CRC if `FRAME_SYNC_CRC_EN` is defined, else go to END.
- CRC:
  - CRC-8: polynomial 0x07, init 0x00, no reflection, no final XOR.
  - Coverage: the length byte and all payload bytes.
  - The received byte is compared with the running CRC; go to END.
- END: internal state, one cycle.
  - Pulse `frame_end_o` and latch `crc_ok_o`.
  - Clear the shift register and the 16-dibit counter; go to HUNT.
  - Any dibit taken during END is discarded.
- `sym_i` is not re-examined after lock; the sync word is not searched for inside a frame.

## Timing
- Reset values:
  - All outputs 0, including `crc_ok_o`.
  - State HUNT; shift register, counters and CRC cleared.
- `rst` overrides `ce`.
- Reset mid-frame: no `frame_end_o` is issued and the partial frame is dropped.
- `byte_valid_o` / `byte_o` are registered: asserted the cycle after the 4th dibit of a byte is taken.
- `frame_start_o` follows the same rule: asserted the cycle after the length byte's 4th dibit is taken.
- `frame_end_o` is asserted 2 cycles after the final byte's 4th dibit is taken (complete → END → output register).
- The final byte is the CRC byte, or the last payload byte when CRC is compiled out.
- `byte_o` holds its value between strobes.
- Gaps (`valid_i` = 0) of any length are allowed anywhere; assembly state is preserved across them.
- Back-to-back frames: the next sync word may start immediately after the END cycle.

## Configuration
- `FRAME_SYNC_CRC_EN` defined:
  - The CRC state, CRC-8 register and trailer byte are present.
  - `crc_ok_o` = (received == computed).
- Not defined:
  - No trailer byte and no CRC logic.
  - `crc_ok_o` is 1 at every `frame_end_o`; it still resets to 0.

## Structure
- Shared package `comm_pkg`:
  - state enum (HUNT, LEN, PAY, CRC, END);
  - `SYNC_WORD_DEFAULT`, `CRC8_POLY` (8'h07).
- Sub-module `crc8_update`: combinational; 8-bit current CRC + 8-bit data → next CRC.

## Test plan
- Sync word 0x1ACFFC1D, length 3, payload 0xA5 0x3C 0x00 (CRC built):
  - `frame_start_o` once;
  - `byte_o` = A5, 3C, 00 on three strobes;
  - `frame_end_o` with `crc_ok_o` = 1.
- Same frame with the CRC byte's bit 0 flipped → identical bytes, then `crc_ok_o` = 0.
- Sync word with 1 bit flipped:
  - `SYNC_TOL` = 0 → stays in HUNT, no strobes.
  - `SYNC_TOL` = 1 → locks.
- Length byte 0x00, then a separate frame with 0x41 (`MAX_LEN` 64) → `len_err_o` pulse for each, `locked_o` falls, no `byte_valid_o`.
- Random `valid_i` gaps of 0–5 cycles with `ce` toggling → same byte sequence as the gap-free run.
- `rst` pulsed after the 2nd payload byte → all outputs 0 next cycle; the next full frame decodes correctly.
